// File: rtl/up5bit_counter_sched.sv
// Round-robin scheduler sharing one WIDTH-bit up-counter between two requesters.
// Each grant clears the counter and runs it for RUN_LEN increments or until the owner withdraws.
module up5bit_counter_sched #(
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned RUN_LEN = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic             done,
  output logic             aborted,
  output logic             wrap
);

  typedef enum logic [1:0] {StIdle, StRun, StRelease} state_e;

  localparam logic [6:0] LastBurst = 7'(RUN_LEN - 1);

  state_e           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [6:0]       burst_q, burst_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             wrap_q, wrap_d;
  logic             winner;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      gnt_q     <= 2'b00;
      count_q   <= '0;
      burst_q   <= '0;
      last_q    <= 1'b1;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      count_q   <= count_d;
      burst_q   <= burst_d;
      last_q    <= last_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      wrap_q    <= wrap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    count_d   = count_q;
    burst_d   = burst_q;
    last_d    = last_q;
    done_d    = done_q;
    aborted_d = aborted_q;
    wrap_d    = 1'b0;
    // On a tie the requester that did not win last time gets the counter.
    winner    = (req == 2'b11) ? ~last_q : req[1];
    unique case (state_q)
      StIdle: begin
        if (req != 2'b00) begin
          state_d = StRun;
          gnt_d   = winner ? 2'b10 : 2'b01;
          count_d = '0;
          burst_d = '0;
          last_d  = winner;
        end
      end
      StRun: begin
        // last_q doubles as the current owner index while running.
        if (req[last_q]) begin
          count_d = count_q + 1'b1;
          burst_d = burst_q + 7'd1;
          wrap_d  = &count_q;
          if (burst_q == LastBurst) begin
            state_d   = StRelease;
            gnt_d     = 2'b00;
            done_d    = 1'b1;
            aborted_d = 1'b0;
          end
        end else begin
          state_d   = StRelease;
          gnt_d     = 2'b00;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end
      end
      StRelease: begin
        state_d   = StIdle;
        done_d    = 1'b0;
        aborted_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy    = (state_q != StIdle);
    gnt     = gnt_q;
    count   = count_q;
    done    = done_q;
    aborted = aborted_q;
    wrap    = wrap_q;
  end

endmodule

// File: tb/tb_up5bit_counter_sched.sv
// Directed bench for up5bit_counter_sched: RUN_LEN=8 instance for most steps,
// RUN_LEN=40 instance for the wrap case.
module tb_up5bit_counter_sched;

  logic       clk = 1'b0;
  logic       reset, reset2;
  logic [1:0] req, req2;
  logic [1:0] gnt, gnt2;
  logic       busy, busy2, done, done2, aborted, aborted2, wrap, wrap2;
  logic [4:0] count, count2;

  int vectors = 0;
  int errors  = 0;
  int wraps   = 0;

  always #5 clk = ~clk;

  up5bit_counter_sched #(.WIDTH(5), .RUN_LEN(8)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt), .busy(busy), .count(count),
    .done(done), .aborted(aborted), .wrap(wrap)
  );

  up5bit_counter_sched #(.WIDTH(5), .RUN_LEN(40)) dut40 (
    .clk(clk), .reset(reset2), .req(req2), .gnt(gnt2), .busy(busy2), .count(count2),
    .done(done2), .aborted(aborted2), .wrap(wrap2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Compact check of the RUN_LEN=8 instance's main outputs.
  task automatic expect8(input string tag, input logic [1:0] g, input logic b,
                         input logic [4:0] c, input logic d, input logic a);
    check({tag, ".gnt"}, 32'(gnt), 32'(g));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".done"}, 32'(done), 32'(d));
    check({tag, ".aborted"}, 32'(aborted), 32'(a));
  endtask

  initial begin
    reset = 1'b0; req = 2'b00; reset2 = 1'b0; req2 = 2'b00;
    step();
    expect8("reset", 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);
    check("reset.wrap", 32'(wrap), 32'd0);

    // Asynchronous reset mid-cycle while running with req=11.
    reset = 1'b1; req = 2'b11;
    step();
    expect8("tie_first", 2'b01, 1'b1, 5'd0, 1'b0, 1'b0);
    step(); step();
    check("pre_async.count", 32'(count), 32'd2);
    #2 reset = 1'b0;
    #1 expect8("async_reset", 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);
    step();
    reset = 1'b1; req = 2'b01;
    step();
    expect8("grant_lat", 2'b01, 1'b1, 5'd0, 1'b0, 1'b0);

    // Full burst of 8 for requester 0.
    for (int k = 1; k <= 7; k++) begin
      step();
      expect8($sformatf("burst0_k%0d", k), 2'b01, 1'b1, 5'(k), 1'b0, 1'b0);
    end
    step();
    expect8("burst0_done", 2'b00, 1'b1, 5'd8, 1'b1, 1'b0);
    req = 2'b00;
    step();
    expect8("burst0_idle", 2'b00, 1'b0, 5'd8, 1'b0, 1'b0);
    step();
    expect8("burst0_hold", 2'b00, 1'b0, 5'd8, 1'b0, 1'b0);

    // Continuous contention: alternating grants, 10-cycle period.
    req = 2'b11;
    step();
    for (int b = 0; b < 4; b++) begin
      logic [1:0] eg;
      eg = (b % 2 == 0) ? 2'b10 : 2'b01;
      expect8($sformatf("rr%0d_grant", b), eg, 1'b1, 5'd0, 1'b0, 1'b0);
      for (int k = 1; k <= 7; k++) begin
        step();
        check($sformatf("rr%0d_count%0d", b, k), 32'(count), 32'(k));
      end
      step();
      expect8($sformatf("rr%0d_done", b), 2'b00, 1'b1, 5'd8, 1'b1, 1'b0);
      if (b == 3) req = 2'b00;
      step();
      expect8($sformatf("rr%0d_idle", b), 2'b00, 1'b0, 5'd8, 1'b0, 1'b0);
      step();
    end
    check("rr_end.gnt", 32'(gnt), 32'd0);

    // Early release after 3 increments, with requester 1 pending.
    req = 2'b01;
    step();
    expect8("abort_grant", 2'b01, 1'b1, 5'd0, 1'b0, 1'b0);
    req = 2'b11;
    step(); step(); step();
    expect8("abort_k3", 2'b01, 1'b1, 5'd3, 1'b0, 1'b0);
    req = 2'b10;
    step();
    expect8("abort_done", 2'b00, 1'b1, 5'd3, 1'b1, 1'b1);
    step();
    expect8("abort_idle", 2'b00, 1'b0, 5'd3, 1'b0, 1'b0);
    step();
    expect8("pending_grant", 2'b10, 1'b1, 5'd0, 1'b0, 1'b0);
    req = 2'b00;
    step();
    expect8("zero_abort", 2'b00, 1'b1, 5'd0, 1'b1, 1'b1);
    step();
    expect8("zero_idle", 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);

    // Reset during RUN at count=5; pointer must also return to its reset value.
    req = 2'b01;
    step();
    step(); step(); step(); step(); step();
    check("pre_reset5.count", 32'(count), 32'd5);
    #2 reset = 1'b0;
    #1 expect8("run_reset", 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);
    step();
    expect8("run_reset_nodone", 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);
    reset = 1'b1; req = 2'b11;
    step();
    expect8("ptr_reset_grant", 2'b01, 1'b1, 5'd0, 1'b0, 1'b0);
    req = 2'b00;
    step(); step();

    // RUN_LEN=40 instance: count wraps once at 31->0.
    reset2 = 1'b1; req2 = 2'b10;
    step();
    check("w40_grant.gnt", 32'(gnt2), 32'h2);
    check("w40_grant.count", 32'(count2), 32'd0);
    check("w40_grant.wrap", 32'(wrap2), 32'd0);
    for (int k = 1; k <= 39; k++) begin
      step();
      if (wrap2 === 1'b1) wraps++;
      check($sformatf("w40_k%0d.count", k), 32'(count2), 32'(k % 32));
      check($sformatf("w40_k%0d.wrap", k), 32'(wrap2), 32'(k == 32));
    end
    step();
    if (wrap2 === 1'b1) wraps++;
    check("w40_done.count", 32'(count2), 32'd8);
    check("w40_done.done", 32'(done2), 32'd1);
    check("w40_done.aborted", 32'(aborted2), 32'd0);
    check("w40_done.gnt", 32'(gnt2), 32'd0);
    check("w40_wrap_total", 32'(wraps), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
